// File: rtl/aes_key_schedule_if.sv
// Bus between the AES key schedule and its user: expansion control, round-key read
// port and the shared S-box lookup.
interface aes_key_schedule_if;
    logic         init;
    logic [255:0] key;
    logic         keylen;
    logic [3:0]   round;
    logic [127:0] round_key;
    logic         ready;
    logic [31:0]  sboxw;
    logic [31:0]  new_sboxw;

    modport master (
        output init, key, keylen, round, new_sboxw,
        input  round_key, ready, sboxw
    );

    modport slave (
        input  init, key, keylen, round, new_sboxw,
        output round_key, ready, sboxw
    );
endinterface

// File: rtl/aes_key_schedule.sv
// AES-128/AES-256 key expansion: one round key per cycle into a 15-entry memory,
// with SubWord supplied by an external shared S-box.
module aes_key_schedule (
    input logic              clk,
    input logic              reset,
    aes_key_schedule_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StGenerate, StDone} state_e;

    state_e       r_state, w_state_next;
    logic         r_ready, w_ready_next;
    logic [3:0]   r_round_ctr, w_round_ctr_next;
    logic [7:0]   r_rcon, w_rcon_next;
    logic [255:0] r_key, w_key_next;
    logic         r_keylen, w_keylen_next;
    logic [127:0] r_prev_key, w_prev_key_next;
    logic [127:0] r_prev_prev_key, w_prev_prev_key_next;
    logic [127:0] r_mem [15];

    logic         w_we;
    logic [127:0] w_new_key;
    logic [127:0] w_base;
    logic [31:0]  w_t, w_rot, w_w0, w_w1, w_w2, w_w3;
    logic [7:0]   w_rcon_gm2, w_rcon_last;
    logic [3:0]   w_last_idx;
    logic         w_derive, w_odd256, w_step_rcon;

    assign bus.sboxw     = r_prev_key[31:0];
    assign bus.ready     = r_ready;
    assign bus.round_key = (bus.round == 4'd15) ? 128'h0 : r_mem[bus.round];

    // Round-key datapath
    always_comb begin
        w_last_idx  = r_keylen ? 4'd14 : 4'd10;
        w_rcon_last = r_keylen ? 8'h40 : 8'h36;
        w_rcon_gm2  = {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);
        w_derive    = (r_round_ctr != 4'd0) && !(r_keylen && (r_round_ctr == 4'd1));
        // AES-256 odd rounds take plain SubWord: no rotate, no rcon
        w_odd256    = r_keylen & r_round_ctr[0];
        w_step_rcon = w_derive & ~w_odd256;
        w_rot       = {bus.new_sboxw[23:0], bus.new_sboxw[31:24]};
        w_t         = w_odd256 ? bus.new_sboxw : (w_rot ^ {r_rcon, 24'h0});
        w_base      = r_keylen ? r_prev_prev_key : r_prev_key;
        w_w0        = w_base[127:96] ^ w_t;
        w_w1        = w_base[95:64] ^ w_w0;
        w_w2        = w_base[63:32] ^ w_w1;
        w_w3        = w_base[31:0] ^ w_w2;
        if (r_round_ctr == 4'd0) begin
            w_new_key = r_key[255:128];
        end else if (!w_derive) begin
            w_new_key = r_key[127:0];
        end else begin
            w_new_key = {w_w0, w_w1, w_w2, w_w3};
        end
    end

    // Control: next state and register updates
    always_comb begin
        w_state_next         = r_state;
        w_ready_next         = r_ready;
        w_round_ctr_next     = r_round_ctr;
        w_rcon_next          = r_rcon;
        w_key_next           = r_key;
        w_keylen_next        = r_keylen;
        w_prev_key_next      = r_prev_key;
        w_prev_prev_key_next = r_prev_prev_key;
        w_we                 = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (bus.init) begin
                    w_key_next       = bus.key;
                    w_keylen_next    = bus.keylen;
                    w_rcon_next      = 8'h01;
                    w_round_ctr_next = 4'd0;
                    w_ready_next     = 1'b0;
                    w_state_next     = StGenerate;
                end
            end
            StGenerate: begin
                w_we                 = 1'b1;
                w_round_ctr_next     = r_round_ctr + 4'd1;
                w_prev_key_next      = w_new_key;
                w_prev_prev_key_next = r_prev_key;
                if (w_step_rcon && (r_rcon != w_rcon_last)) begin
                    w_rcon_next = w_rcon_gm2;
                end
                if (r_round_ctr == w_last_idx) begin
                    w_state_next = StDone;
                end
            end
            StDone: begin
                w_ready_next = 1'b1;
                w_state_next = StIdle;
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ready         <= 1'b1;
            r_round_ctr     <= 4'd0;
            r_rcon          <= 8'h01;
            r_key           <= 256'h0;
            r_keylen        <= 1'b0;
            r_prev_key      <= 128'h0;
            r_prev_prev_key <= 128'h0;
            for (int i = 0; i < 15; i++) begin
                r_mem[i] <= 128'h0;
            end
        end else begin
            r_ready         <= w_ready_next;
            r_round_ctr     <= w_round_ctr_next;
            r_rcon          <= w_rcon_next;
            r_key           <= w_key_next;
            r_keylen        <= w_keylen_next;
            r_prev_key      <= w_prev_key_next;
            r_prev_prev_key <= w_prev_prev_key_next;
            if (w_we) begin
                r_mem[r_round_ctr] <= w_new_key;
            end
        end
    end
endmodule

// File: tb/tb_aes_key_schedule.sv
// Bench for aes_key_schedule: FIPS-197 vectors, corner sequences and random keys
// checked against a word-level FIPS-197 key expansion model.
module tb_aes_key_schedule;
    logic clk;
    logic reset;
    int   total;
    int   bad;

    aes_key_schedule_if bus ();

    aes_key_schedule dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h0; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = xtime(x);
            y = y >> 1;
        end
        return p;
    endfunction

    // S-box from its definition: GF(2^8) inverse followed by the affine map
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] v, s;
        v = 8'h0;
        if (x != 8'h0) begin
            for (int y = 1; y < 256; y++) begin
                if (gmul(x, 8'(y)) == 8'h01) v = 8'(y);
            end
        end
        s = v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
        return s;
    endfunction

    function automatic logic [31:0] subword(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    assign bus.new_sboxw = subword(bus.sboxw);

    function automatic logic [127:0] ref_rk(input logic [255:0] k, input logic kl, input int idx);
        logic [31:0] w [60];
        logic [31:0] tmp;
        logic [7:0]  rc;
        int          nk, nw;
        nk = kl ? 8 : 4;
        nw = kl ? 60 : 44;
        for (int i = 0; i < 60; i++) w[i] = 32'h0;
        for (int i = 0; i < nk; i++) w[i] = k[255 - 32 * i -: 32];
        rc = 8'h01;
        for (int i = nk; i < nw; i++) begin
            tmp = w[i - 1];
            if (i % nk == 0) begin
                tmp = subword({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
                rc  = xtime(rc);
            end else if (nk == 8 && i % nk == 4) begin
                tmp = subword(tmp);
            end
            w[i] = w[i - nk] ^ tmp;
        end
        return {w[4 * idx], w[4 * idx + 1], w[4 * idx + 2], w[4 * idx + 3]};
    endfunction

    logic [127:0] model_mem [15];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 15; i++) model_mem[i] = 128'h0;
    endtask

    task automatic model_update(input logic [255:0] k, input logic kl);
        for (int i = 0; i <= (kl ? 14 : 10); i++) model_mem[i] = ref_rk(k, kl, i);
    endtask

    task automatic check_all(input string nm);
        for (int i = 0; i < 16; i++) begin
            bus.round = 4'(i);
            #1;
            chk($sformatf("%s_idx%0d", nm, i), bus.round_key, (i == 15) ? 128'h0 : model_mem[i]);
        end
    endtask

    task automatic kick(input logic [255:0] k, input logic kl);
        @(negedge clk);
        bus.round  = 4'd15;
        bus.key    = k;
        bus.keylen = kl;
        bus.init   = 1'b1;
        @(posedge clk);
        #1;
        bus.init = 1'b0;
    endtask

    // Counts post-edge samples with ready low; round 15 must read zero throughout
    task automatic wait_ready(input int already, input int expect_cyc, input string nm);
        int cnt;
        cnt = already;
        while (!bus.ready && cnt < 200) begin
            chk("rd15_busy", bus.round_key, 128'h0);
            cnt++;
            @(posedge clk);
            #1;
        end
        chk(nm, 128'(cnt), 128'(expect_cyc));
    endtask

    task automatic run(input logic [255:0] k, input logic kl, input string nm);
        kick(k, kl);
        wait_ready(0, kl ? 16 : 12, {nm, "_ready_cycles"});
        model_update(k, kl);
        check_all(nm);
    endtask

    typedef struct {
        logic [255:0] key;
        logic         keylen;
        logic [3:0]   idx;
        logic [127:0] exp;
    } vec_t;

    localparam logic [255:0] KeyA1 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] KeyA3 =
        256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    initial begin
        vec_t         vecs [8];
        logic [255:0] last_key;
        logic         last_kl;
        logic [255:0] rk;
        logic         rkl;

        total = 0;
        bad   = 0;
        vecs[0] = '{KeyA1, 1'b0, 4'd0,  128'h2b7e151628aed2a6abf7158809cf4f3c};
        vecs[1] = '{KeyA1, 1'b0, 4'd1,  128'ha0fafe1788542cb123a339392a6c7605};
        vecs[2] = '{KeyA1, 1'b0, 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
        vecs[3] = '{KeyA1, 1'b0, 4'd15, 128'h0};
        vecs[4] = '{KeyA3, 1'b1, 4'd0,  128'h603deb1015ca71be2b73aef0857d7781};
        vecs[5] = '{KeyA3, 1'b1, 4'd1,  128'h1f352c073b6108d72d9810a30914dff4};
        vecs[6] = '{KeyA3, 1'b1, 4'd2,  128'h9ba354118e6925afa51a8b5f2067fcde};
        vecs[7] = '{KeyA3, 1'b1, 4'd14, 128'hfe4890d1e6188d0b046df344706c631e};

        bus.init   = 1'b0;
        bus.key    = 256'h0;
        bus.keylen = 1'b0;
        bus.round  = 4'd0;
        reset      = 1'b1;
        model_clear();
        #23;
        chk("reset_ready", 128'(bus.ready), 128'h1);
        chk("reset_sboxw", 128'(bus.sboxw), 128'h0);
        check_all("reset");
        @(negedge clk);
        reset = 1'b0;

        last_key = 256'h0;
        last_kl  = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i == 0 || vecs[i].key != last_key || vecs[i].keylen != last_kl) begin
                run(vecs[i].key, vecs[i].keylen, "fips");
                last_key = vecs[i].key;
                last_kl  = vecs[i].keylen;
            end
            bus.round = vecs[i].idx;
            #1;
            chk($sformatf("vec%0d", i), bus.round_key, vecs[i].exp);
        end

        // AES-128 over an AES-256 result: upper entries must survive
        run(KeyA1, 1'b0, "a128_after_a256");
        bus.round = 4'd14;
        #1;
        chk("keep_idx14", bus.round_key, 128'hfe4890d1e6188d0b046df344706c631e);

        // Second init with a new key mid-expansion is ignored
        kick(KeyA3, 1'b1);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        bus.init   = 1'b1;
        bus.key    = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        bus.keylen = 1'b0;
        @(posedge clk);
        #1;
        bus.init = 1'b0;
        wait_ready(5, 16, "glitch_ready_cycles");
        model_update(KeyA3, 1'b1);
        check_all("glitch");

        // Reset in the middle of an AES-128 expansion
        kick(KeyA1, 1'b0);
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        #1;
        chk("abort_ready", 128'(bus.ready), 128'h1);
        model_clear();
        check_all("abort");
        @(negedge clk);
        reset = 1'b0;
        run(KeyA1, 1'b0, "after_abort");

        for (int n = 0; n < 6; n++) begin
            rk  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            rkl = 1'($urandom_range(0, 1));
            run(rk, rkl, $sformatf("rand%0d", n));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/aes_key_schedule.md
AES_KEY_SCHEDULE -- requirements
Module: aes_key_schedule

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, exposed as the ports below.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 init  in  1  single-cycle request to start key expansion.
REQ-005 key  in  256  cipher key; AES-128 uses key[255:128] only.
REQ-006 keylen  in  1  0 = AES-128 (11 round keys), 1 = AES-256 (15 round keys).
REQ-007 round  in  4  round key index to read.
REQ-008 round_key  out  128  round key stored at index round.
REQ-009 ready  out  1  high when idle and all round keys are valid.
REQ-010 sboxw  out  32  word sent to the shared S-box.
REQ-011 new_sboxw  in  32  SubWord(sboxw), returned combinationally by the shared S-box.

Function
REQ-012 The block SHALL contain a key memory of 15 entries of 128 bits, indices 0..14.
REQ-013 round_key SHALL be a combinational read of entry round.
REQ-014 round = 15 SHALL return 128'h0.
REQ-015 The control FSM SHALL have three states: IDLE, GENERATE and DONE.
REQ-016 In IDLE with init=1, the block SHALL register key, keylen and rcon=8'h01, clear round_ctr to 0, drop ready at the same edge, and go to GENERATE.
REQ-017 In GENERATE, one round key SHALL be written per cycle to entry round_ctr, and round_ctr SHALL increment by 1.
REQ-018 Round key 0 SHALL be key_reg[255:128].
REQ-019 For AES-256, round key 1 SHALL be key_reg[127:0].
REQ-020 Each later key SHALL be derived from prev_key and, for AES-256, also from prev_prev_key, both held in registers.
REQ-021 sboxw SHALL equal prev_key[31:0] (w3 of the previous key).
REQ-022 For AES-128 rounds 1..10, t = RotWord(new_sboxw) ^ {rcon,24'h0}, and rcon SHALL then step to gm2(rcon).
- RotWord is a left rotate by 8 bits.
- gm2 is multiply-by-2 in GF(2^8) with polynomial 0x11b.
REQ-023 For AES-128, w0 = prev[127:96]^t, w1 = prev[95:64]^w0, w2 = prev[63:32]^w1, w3 = prev[31:0]^w2.
REQ-024 For AES-256 even rounds >= 2, t SHALL be computed as in REQ-022 (RotWord and rcon step).
REQ-025 For AES-256 odd rounds >= 3, t = new_sboxw, with no rotate and no rcon step.
REQ-026 For AES-256 rounds >= 2, the w0..w3 chain SHALL use prev_prev_key in place of prev.
REQ-027 After writing index 10 (AES-128) or index 14 (AES-256), the FSM SHALL go to DONE.
REQ-028 DONE SHALL set ready=1 and return to IDLE on the next edge.
- ready therefore rises 12 cycles (AES-128) or 16 cycles (AES-256) after the init edge.
REQ-029 init SHALL be ignored in GENERATE and DONE.
REQ-030 Changes on key and keylen after the init edge SHALL NOT affect the expansion in progress.
REQ-031 During GENERATE, reads of indices not yet written SHALL return their previous contents.
REQ-032 In GENERATE, rcon SHALL NOT step past 8'h36 (AES-128) or 8'h40 (AES-256).

Reset
REQ-033 Reset SHALL asynchronously set the following:
- FSM = IDLE, ready = 1, round_ctr = 0, rcon = 8'h01.
- key_reg, keylen_reg, prev_key and prev_prev_key = 0.
- All 15 memory entries = 128'h0.
REQ-034 Reset during GENERATE SHALL abort the expansion and leave the REQ-033 values.
REQ-035 After reset is released, the first init SHALL start a full expansion.

Verification
REQ-036 AES-128 (FIPS-197 A.1): key[255:128] = 2b7e151628aed2a6abf7158809cf4f3c, keylen=0, init pulse.
- ready low for 12 cycles.
- round 1 = a0fafe1788542cb123a339392a6c7605.
- round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
REQ-037 AES-256 (FIPS-197 A.3): key = 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, keylen=1.
- ready low for 16 cycles.
- round 2 = 9ba354118e6925afa51a8b5f2067fcde.
- round 14 = fe4890d1e6188d0b046df344706c631e.
REQ-038 Init pulse at cycle 5 of an AES-256 run, with key changed at the same time -> ignored; the final round keys still match REQ-037.
REQ-039 Reset asserted at cycle 6 of an AES-128 run -> ready=1 immediately and all indices read 0; a new init then produces the REQ-036 values.
REQ-040 Read with round=15 -> round_key = 128'h0 in every state.
REQ-041 AES-128 run directly after an AES-256 run -> indices 0..10 match REQ-036; indices 11..14 keep their AES-256 values.
